mem_access_unit: RTL and testbench

- MEM-stage load/store unit between the pipelined datapath and a handshaked SRAM-like data bus.
- Takes the EX/MEM address (EXResultM) and store data (WriteDataM), and issues one bus transaction per memory instruction.
- Formats load data into ReadDataM and raises MemStallM until the transaction completes.
- Replaces the fixed single-cycle data-RAM assumption so multi-cycle memories can be attached.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_lane_fmt.sv | 48 ++++
 rtl/mem_access_unit.sv | 138 +++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes and FSM states.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } mem_state_e;

  // Reserved size code 3 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'd3) ? MEM_WORD : s;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store replication/byte enables and load lane extract/extend.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_a,
  input  logic [31:0] i_wd,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_signed,
  input  logic [1:0]  i_ld_a,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_rdata
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;

  assign w_byte_sh = i_rword >> {i_ld_a, 3'b000};
  assign w_half_sh = i_rword >> {i_ld_a[1], 4'b0000};

  always_comb begin
    o_wdata = i_wd;
    o_wstrb = 4'b1111;
    case (norm_size(i_st_size))
      MEM_BYTE: begin
        o_wdata = {4{i_wd[7:0]}};
        o_wstrb = 4'b0001 << i_st_a;
      end
      MEM_HALF: begin
        o_wdata = {2{i_wd[15:0]}};
        o_wstrb = 4'b0011 << {i_st_a[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_rdata = i_rword;
    case (norm_size(i_ld_size))
      MEM_BYTE: o_rdata = {{24{i_ld_signed & w_byte_sh[7]}}, w_byte_sh[7:0]};
      MEM_HALF: o_rdata = {{16{i_ld_signed & w_half_sh[15]}}, w_half_sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving a handshaked data bus.
// MEM_ALIGN_CHECK_EN: flag misaligned accesses instead of force-aligning them.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReqM,
  input  logic              MemWriteM,
  input  logic [1:0]        MemSizeM,
  input  logic              MemSignedM,
  input  logic [ADDR_W-1:0] EXResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              MemAdvanceM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              MemStallM,
  output logic              AddrErrM,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  mem_state_e        r_state, w_next;
  logic              w_err, w_req, w_stall, w_done, w_accept;
  logic [1:0]        w_size_n, w_a_lo;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, w_rdata;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] r_rword;
  logic [1:0]        r_a, r_size;
  logic              r_signed, r_wr;

  assign w_size_n = norm_size(MemSizeM);

`ifdef MEM_ALIGN_CHECK_EN
  logic w_misal;
  assign w_misal = ((w_size_n == MEM_HALF) & EXResultM[0]) |
                   ((w_size_n == MEM_WORD) & (|EXResultM[1:0]));
  assign w_err   = MemReqM & w_misal;
  assign w_a_lo  = EXResultM[1:0];
`else
  assign w_err   = 1'b0;
  assign w_a_lo  = (w_size_n == MEM_WORD) ? 2'b00 :
                   (w_size_n == MEM_HALF) ? {EXResultM[1], 1'b0} : EXResultM[1:0];
`endif

  assign w_addr = {EXResultM[ADDR_W-1:2], w_a_lo};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (MemReqM & ~w_err) w_next = data_addr_ok ? WAIT_DATA : REQ;
      REQ:       if (data_addr_ok) w_next = WAIT_DATA;
      WAIT_DATA: if (data_data_ok) w_next = DONE;
      DONE:      if (MemAdvanceM) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_req   = MemReqM & ~w_err;
        w_stall = MemReqM & ~w_err;
      end
      REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
      end
      WAIT_DATA: w_stall = 1'b1;
      DONE:      w_done  = 1'b1;
      default: ;
    endcase
  end

  // Request fields come straight from the stalled EX/MEM inputs; only the
  // lane-select context is captured so the load can be formatted later.
  assign w_accept = data_req & data_addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rword  <= '0;
      r_a      <= 2'b00;
      r_size   <= MEM_BYTE;
      r_signed <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= w_a_lo;
        r_size   <= w_size_n;
        r_signed <= MemSignedM;
        r_wr     <= MemWriteM;
      end
      if (r_state == WAIT_DATA && data_data_ok) r_rword <= data_rdata;
    end
  end

  mem_lane_fmt u_fmt (
    .i_st_size   (w_size_n),
    .i_st_a      (w_a_lo),
    .i_wd        (WriteDataM),
    .i_ld_size   (r_size),
    .i_ld_signed (r_signed),
    .i_ld_a      (r_a),
    .i_rword     (r_rword),
    .o_wdata     (w_wdata),
    .o_wstrb     (w_wstrb),
    .o_rdata     (w_rdata)
  );

  assign data_req   = w_req & ~rst;
  assign MemStallM  = w_stall & ~rst;
  assign AddrErrM   = w_err & ~rst;
  assign data_wr    = data_req & MemWriteM;
  assign data_size  = data_req ? MemSizeM : 2'b00;
  assign data_addr  = data_req ? w_addr : '0;
  assign data_wdata = data_wr ? w_wdata : '0;
  assign data_wstrb = data_wr ? w_wstrb : 4'b0000;
  assign ReadDataM  = (w_done & ~r_wr & ~rst) ? w_rdata : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level expectation model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReqM, MemWriteM, MemSignedM, MemAdvanceM;
  logic [1:0]  MemSizeM;
  logic [31:0] EXResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM, AddrErrM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .MemSizeM(MemSizeM), .MemSignedM(MemSignedM), .EXResultM(EXResultM),
    .WriteDataM(WriteDataM), .MemAdvanceM(MemAdvanceM), .ReadDataM(ReadDataM),
    .MemStallM(MemStallM), .AddrErrM(AddrErrM), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  // 0 idle, 1 request pending, 2 awaiting data, 3 load/store done, 4 reset, 5 misaligned
  int phase = 4;
  int stall_cnt = 0;
  int hs_cnt = 0;
  logic [31:0] m_a, m_wd, m_rw;
  logic [1:0]  m_sz;
  logic        m_wr, m_sg;
  logic [31:0] last_rd, last_wdata;
  logic [3:0]  last_wstrb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_addr(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_ALIGN_CHECK_EN
    return a;
`else
    if (sz == 2'd1) return a - (a % 2);
    if (sz >= 2'd2) return a - (a % 4);
    return a;
`endif
  endfunction

  function automatic logic f_err(input logic req, input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_ALIGN_CHECK_EN
    return req && ((sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] f_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return (wd % 256) * 32'h01010101;
    if (sz == 2'd1) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [31:0] a, input logic [1:0] sz);
    int off;
    off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << ((off / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] rw, input logic [31:0] a,
                                         input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    if (sz == 2'd0) begin
      v = (rw >> (8 * off)) % 256;
      if (sg && v >= 128) v = v + 32'hFFFFFF00;
      return v;
    end
    if (sz == 2'd1) begin
      v = (rw >> ((off / 2) * 16)) % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF0000;
      return v;
    end
    return rw;
  endfunction

  always @(negedge clk) begin
    case (phase)
      0: begin
        chk("idle_req", data_req, 0);
        chk("idle_stall", MemStallM, 0);
        chk("idle_rdata", ReadDataM, 0);
      end
      1: begin
        chk("req_req", data_req, 1);
        chk("req_stall", MemStallM, 1);
        chk("req_addr", data_addr, f_addr(m_a, m_sz));
        chk("req_size", data_size, m_sz);
        chk("req_wr", data_wr, m_wr);
        chk("req_wdata", data_wdata, m_wr ? f_wdata(m_wd, m_sz) : 32'h0);
        chk("req_wstrb", data_wstrb, m_wr ? f_wstrb(f_addr(m_a, m_sz), m_sz) : 4'h0);
        last_wdata = data_wdata;
        last_wstrb = data_wstrb;
      end
      2: begin
        chk("wait_req", data_req, 0);
        chk("wait_stall", MemStallM, 1);
      end
      3: begin
        chk("done_req", data_req, 0);
        chk("done_stall", MemStallM, 0);
        chk("done_rdata", ReadDataM,
            m_wr ? 32'h0 : f_load(m_rw, f_addr(m_a, m_sz), m_sz, m_sg));
        last_rd = ReadDataM;
      end
      4: begin
        chk("rst_req", data_req, 0);
        chk("rst_stall", MemStallM, 0);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_err", AddrErrM, 0);
        chk("rst_wr", data_wr, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_wstrb", data_wstrb, 0);
        chk("rst_size", data_size, 0);
      end
      5: begin
        chk("err_req", data_req, 0);
        chk("err_stall", MemStallM, 0);
      end
      default: ;
    endcase
    if (phase != 4) chk("addr_err", AddrErrM, f_err(MemReqM, m_a, m_sz));
    if (MemStallM) stall_cnt++;
    if (data_req && data_addr_ok) hs_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                           input int aok_dly, input int adv_dly);
    m_wr = wr; m_sz = sz; m_sg = sg; m_a = a; m_wd = wd; m_rw = rw;
    MemReqM = 1'b1; MemWriteM = wr; MemSizeM = sz; MemSignedM = sg;
    EXResultM = a; WriteDataM = wd; MemAdvanceM = 1'b0;
    stall_cnt = 0; hs_cnt = 0;
    phase = 1;
    for (int i = 0; i < aok_dly; i++) begin
      data_addr_ok = 1'b0;
      step();
    end
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = rw;
    phase = 2;
    step();
    data_data_ok = 1'b0;
    data_rdata = 32'h5A5A5A5A;
    phase = 3;
    for (int i = 0; i < adv_dly; i++) step();
    MemAdvanceM = 1'b1;
    step();
    MemAdvanceM = 1'b0;
    MemReqM = 1'b0;
    phase = 0;
    step();
    chk("stall_cycles", stall_cnt, aok_dly + 2);
    chk("handshakes", hs_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    MemReqM = 0; MemWriteM = 0; MemSizeM = 0; MemSignedM = 0; MemAdvanceM = 0;
    EXResultM = 0; WriteDataM = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    m_a = 0; m_wd = 0; m_rw = 0; m_sz = 0; m_wr = 0; m_sg = 0;
    phase = 4;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    phase = 0;
    step();

    do_access(0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    chk("lit_word_load", last_rd, 32'hDEADBEEF);
    do_access(0, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 0, 0);
    chk("lit_sbyte_load", last_rd, 32'hFFFFFF80);
    do_access(0, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 0, 0);
    chk("lit_ubyte_load", last_rd, 32'h00000080);
    do_access(1, 2'd1, 0, 32'h202, 32'h0000ABCD, 32'h0, 0, 0);
    chk("lit_half_wdata", last_wdata, 32'hABCDABCD);
    chk("lit_half_wstrb", last_wstrb, 4'b1100);
    do_access(1, 2'd0, 0, 32'h101, 32'h12345677, 32'h0, 3, 0);
    chk("lit_byte_wdata", last_wdata, 32'h77777777);
    chk("lit_byte_wstrb", last_wstrb, 4'b0010);
    do_access(0, 2'd1, 1, 32'h102, 32'h0, 32'h80017FFF, 1, 2);
    chk("lit_shalf_load", last_rd, 32'hFFFF8001);
    do_access(1, 2'd3, 0, 32'h104, 32'hCAFEF00D, 32'h0, 0, 1);
    chk("lit_sz3_wstrb", last_wstrb, 4'b1111);

`ifdef MEM_ALIGN_CHECK_EN
    m_wr = 0; m_sz = 2'd2; m_sg = 0; m_a = 32'h101;
    MemReqM = 1; MemWriteM = 0; MemSizeM = 2'd2; EXResultM = 32'h101;
    phase = 5;
    chk("lit_err_word", AddrErrM, 1);
    step();
    m_sz = 2'd1; m_a = 32'h203;
    MemSizeM = 2'd1; EXResultM = 32'h203;
    chk("lit_err_half", AddrErrM, 1);
    step();
    MemReqM = 0;
    phase = 0;
    step();
`else
    do_access(0, 2'd2, 0, 32'h101, 32'h0, 32'h11223344, 0, 0);
    chk("lit_misal_word", last_rd, 32'h11223344);
    do_access(0, 2'd1, 0, 32'h201, 32'h0, 32'hAAAA5555, 0, 0);
    chk("lit_misal_half", last_rd, 32'h00005555);
`endif

    // Abort a load in WAIT_DATA and return a stale response after reset.
    m_wr = 0; m_sz = 2'd2; m_sg = 0; m_a = 32'h300;
    MemReqM = 1; MemWriteM = 0; MemSizeM = 2'd2; EXResultM = 32'h300;
    data_addr_ok = 1;
    phase = 1;
    step();
    data_addr_ok = 0;
    phase = 2;
    step();
    rst = 1;
    MemReqM = 0;
    phase = 4;
    step();
    rst = 0;
    phase = 0;
    data_data_ok = 1;
    data_rdata = 32'hFFFFFFFF;
    step();
    data_data_ok = 0;
    step();
    chk("lit_post_rst_rdata", ReadDataM, 32'h0);
    step();

    do_access(0, 2'd2, 0, 32'h400, 32'h0, 32'h13579BDF, 0, 0);
    chk("lit_after_rst_load", last_rd, 32'h13579BDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
